// File: rtl/regfile_sb.sv
// Two-write-port register file with optional write-to-read bypass and a busy scoreboard.
// Supplies operands, flags RAW/WAW hazards and tracks how many registers are waiting for writeback.
module regfile_sb #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16,
    parameter int ADDR_W = 4,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              issue_use1,
    input  logic              issue_use2,
    output logic              issue_stall,
    output logic [ADDR_W:0]   pending_cnt
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_nxt;
    logic [NREGS-1:0]  set_vec;
    logic [NREGS-1:0]  clr_vec;
    logic [ADDR_W:0]   n_rise;
    logic [ADDR_W:0]   n_fall;
    logic [ADDR_W:0]   cnt_q;
    logic              waw;
    logic              issue_fire;

    // Returns {busy, data} as seen by a read port; wr1 beats wr0 when both hit.
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] addr,
                                               input logic [DATA_W-1:0] stored_data,
                                               input logic              stored_busy);
        logic [DATA_W:0] res;
        res = {stored_busy, stored_data};
        if (addr == '0) begin
            res = '0;
        end else if (BYPASS && wr1_en && (wr1_addr == addr)) begin
            res = {1'b0, wr1_data};
        end else if (BYPASS && wr0_en && (wr0_addr == addr)) begin
            res = {1'b0, wr0_data};
        end
        return res;
    endfunction

    always_comb begin
        logic [DATA_W:0] r1;
        logic [DATA_W:0] r2;
        logic [DATA_W:0] rd;
        r1 = lookup(rs1_addr, regs[rs1_addr], busy[rs1_addr]);
        r2 = lookup(rs2_addr, regs[rs2_addr], busy[rs2_addr]);
        rd = lookup(issue_rd, regs[issue_rd], busy[issue_rd]);
        rs1_data = r1[DATA_W-1:0];
        rs1_busy = r1[DATA_W];
        rs2_data = r2[DATA_W-1:0];
        rs2_busy = r2[DATA_W];
        waw      = rd[DATA_W];
    end

    // Handshake: issue_valid is the request, !issue_stall the grant; an instruction
    // issues (and claims issue_rd) only in a cycle where both hold.
    assign issue_stall = issue_valid & ((issue_use1 & rs1_busy) | (issue_use2 & rs2_busy) | waw);
    assign issue_fire  = issue_valid & ~issue_stall;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (wr0_en) clr_vec[wr0_addr] = 1'b1;
        if (wr1_en) clr_vec[wr1_addr] = 1'b1;
        if (issue_fire) set_vec[issue_rd] = 1'b1;
        set_vec[0] = 1'b0;
        clr_vec[0] = 1'b0;
        // Set dominates clear so a re-claimed register stays busy.
        busy_nxt = set_vec | (busy & ~clr_vec);
    end

    // Counter moves by the number of bits that actually changed, so it tracks popcount.
    always_comb begin
        n_rise = '0;
        n_fall = '0;
        for (int i = 0; i < NREGS; i++) begin
            n_rise = n_rise + (ADDR_W+1)'(busy_nxt[i] & ~busy[i]);
            n_fall = n_fall + (ADDR_W+1)'(busy[i] & ~busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            busy  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr0_en && (wr0_addr != '0)) regs[wr0_addr] <= wr0_data;
            if (wr1_en && (wr1_addr != '0)) regs[wr1_addr] <= wr1_data;
            busy  <= busy_nxt;
            cnt_q <= cnt_q + n_rise - n_fall;
        end
    end

    assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one instance with bypass and one without, both checked every
// cycle against a behavioural model, plus directed literal expectations.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [3:0]  rs1_addr, rs2_addr;
    logic        wr0_en, wr1_en;
    logic [3:0]  wr0_addr, wr1_addr;
    logic [15:0] wr0_data, wr1_data;
    logic        issue_valid, issue_use1, issue_use2;
    logic [3:0]  issue_rd;

    logic [15:0] rs1_data_b1, rs2_data_b1, rs1_data_b0, rs2_data_b0;
    logic        rs1_busy_b1, rs2_busy_b1, rs1_busy_b0, rs2_busy_b0;
    logic        stall_b1, stall_b0;
    logic [4:0]  cnt_b1, cnt_b0;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_sb #(.DATA_W(16), .NREGS(16), .ADDR_W(4), .BYPASS(1'b1)) dut_b1 (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data_b1), .rs2_data(rs2_data_b1),
        .rs1_busy(rs1_busy_b1), .rs2_busy(rs2_busy_b1),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_use1(issue_use1), .issue_use2(issue_use2),
        .issue_stall(stall_b1), .pending_cnt(cnt_b1)
    );

    regfile_sb #(.DATA_W(16), .NREGS(16), .ADDR_W(4), .BYPASS(1'b0)) dut_b0 (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data_b0), .rs2_data(rs2_data_b0),
        .rs1_busy(rs1_busy_b0), .rs2_busy(rs2_busy_b0),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_use1(issue_use1), .issue_use2(issue_use2),
        .issue_stall(stall_b0), .pending_cnt(cnt_b0)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- model (index = bypass flag) ----------------
    logic [15:0] m_regs [2][16];
    logic        m_busy [2][16];

    function automatic logic [15:0] exp_data(int b, logic [3:0] a);
        if (a == 4'd0) return 16'h0;
        if (b == 1 && wr1_en && wr1_addr == a) return wr1_data;
        if (b == 1 && wr0_en && wr0_addr == a) return wr0_data;
        return m_regs[b][a];
    endfunction

    function automatic logic exp_busy(int b, logic [3:0] a);
        if (a == 4'd0) return 1'b0;
        if (b == 1 && ((wr1_en && wr1_addr == a) || (wr0_en && wr0_addr == a))) return 1'b0;
        return m_busy[b][a];
    endfunction

    function automatic logic exp_stall(int b);
        if (!issue_valid) return 1'b0;
        return (issue_use1 && exp_busy(b, rs1_addr)) || (issue_use2 && exp_busy(b, rs2_addr))
               || exp_busy(b, issue_rd);
    endfunction

    function automatic logic [4:0] exp_cnt(int b);
        int n = 0;
        for (int i = 0; i < 16; i++) if (m_busy[b][i]) n++;
        return 5'(n);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < 16; i++) begin
                    m_regs[b][i] = '0;
                    m_busy[b][i] = 1'b0;
                end
        end else begin
            for (int b = 0; b < 2; b++) begin
                logic st;
                st = exp_stall(b);
                if (wr0_en && wr0_addr != 0) begin
                    m_regs[b][wr0_addr] = wr0_data;
                    m_busy[b][wr0_addr] = 1'b0;
                end
                if (wr1_en && wr1_addr != 0) begin
                    m_regs[b][wr1_addr] = wr1_data;
                    m_busy[b][wr1_addr] = 1'b0;
                end
                if (issue_valid && !st && issue_rd != 0) m_busy[b][issue_rd] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("b1_rs1_data", 32'(rs1_data_b1), 32'(exp_data(1, rs1_addr)));
        check("b1_rs2_data", 32'(rs2_data_b1), 32'(exp_data(1, rs2_addr)));
        check("b1_rs1_busy", 32'(rs1_busy_b1), 32'(exp_busy(1, rs1_addr)));
        check("b1_rs2_busy", 32'(rs2_busy_b1), 32'(exp_busy(1, rs2_addr)));
        check("b1_stall",    32'(stall_b1),    32'(exp_stall(1)));
        check("b1_cnt",      32'(cnt_b1),      32'(exp_cnt(1)));
        check("b0_rs1_data", 32'(rs1_data_b0), 32'(exp_data(0, rs1_addr)));
        check("b0_rs2_data", 32'(rs2_data_b0), 32'(exp_data(0, rs2_addr)));
        check("b0_rs1_busy", 32'(rs1_busy_b0), 32'(exp_busy(0, rs1_addr)));
        check("b0_rs2_busy", 32'(rs2_busy_b0), 32'(exp_busy(0, rs2_addr)));
        check("b0_stall",    32'(stall_b0),    32'(exp_stall(0)));
        check("b0_cnt",      32'(cnt_b0),      32'(exp_cnt(0)));
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        rs1_addr = 0; rs2_addr = 0;
        wr0_en = 0; wr0_addr = 0; wr0_data = 0;
        wr1_en = 0; wr1_addr = 0; wr1_data = 0;
        issue_valid = 0; issue_rd = 0; issue_use1 = 0; issue_use2 = 0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_issue(input logic [3:0] rd, input logic u1, input logic [3:0] a1);
        issue_valid = 1; issue_rd = rd; issue_use1 = u1; rs1_addr = a1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1;
        idle();
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cnt", 32'(cnt_b1), 32'd0);
        check("rst_rs1", 32'(rs1_data_b1), 32'd0);
        rst = 1'b1;

        // Write R5, read it back.
        wr0_en = 1; wr0_addr = 5; wr0_data = 16'h1234;
        adv();
        rs1_addr = 5;
        settle();
        check("r5_b1", 32'(rs1_data_b1), 32'h1234);
        check("r5_b0", 32'(rs1_data_b0), 32'h1234);
        adv();

        // R0 writes and issues are ignored.
        wr0_en = 1; wr0_addr = 0; wr0_data = 16'hFFFF;
        issue_valid = 1; issue_rd = 0;
        adv();
        settle();
        check("r0_data", 32'(rs1_data_b1), 32'd0);
        check("r0_cnt",  32'(cnt_b1), 32'd0);
        adv();

        // Both ports hit R3; wr1 wins.
        wr0_en = 1; wr0_addr = 3; wr0_data = 16'h1111;
        wr1_en = 1; wr1_addr = 3; wr1_data = 16'h2222;
        rs1_addr = 3;
        settle();
        check("prio_bypass", 32'(rs1_data_b1), 32'h2222);
        adv();
        rs2_addr = 3;
        settle();
        check("prio_b1", 32'(rs2_data_b1), 32'h2222);
        check("prio_b0", 32'(rs2_data_b0), 32'h2222);
        adv();

        // RAW on R4.
        do_issue(4, 0, 0);
        adv();
        do_issue(7, 1, 4);
        settle();
        check("raw_b1", 32'(stall_b1), 32'd1);
        check("raw_b0", 32'(stall_b0), 32'd1);
        adv();
        do_issue(7, 1, 4);
        wr0_en = 1; wr0_addr = 4; wr0_data = 16'hBEEF;
        settle();
        check("raw_byp_stall", 32'(stall_b1), 32'd0);
        check("raw_byp_data",  32'(rs1_data_b1), 32'hBEEF);
        check("raw_nobyp_stall", 32'(stall_b0), 32'd1);
        adv();
        do_issue(7, 1, 4);
        settle();
        check("raw_nobyp_next", 32'(stall_b0), 32'd0);
        check("raw_nobyp_data", 32'(rs1_data_b0), 32'hBEEF);
        check("waw_r7_b1", 32'(stall_b1), 32'd1);
        adv();
        wr1_en = 1; wr1_addr = 7; wr1_data = 16'h0007;
        adv();

        // Set/clear collision on R6.
        do_issue(6, 0, 0);
        adv();
        do_issue(6, 0, 0);
        wr1_en = 1; wr1_addr = 6; wr1_data = 16'h6666;
        settle();
        check("coll_b1_stall", 32'(stall_b1), 32'd0);
        check("coll_b0_stall", 32'(stall_b0), 32'd1);
        adv();
        do_issue(6, 0, 0);
        settle();
        check("coll_b1_cnt", 32'(cnt_b1), 32'd1);
        check("coll_b0_cnt", 32'(cnt_b0), 32'd0);
        check("waw_r6_b1", 32'(stall_b1), 32'd1);
        adv();
        wr0_en = 1; wr0_addr = 6; wr0_data = 16'h0606;
        adv();
        settle();
        check("clr_cnt_b1", 32'(cnt_b1), 32'd0);
        check("clr_cnt_b0", 32'(cnt_b0), 32'd0);
        adv();

        // Fill the scoreboard, then drain two per cycle.
        for (int i = 1; i < 16; i++) begin
            do_issue(4'(i), 0, 0);
            adv();
        end
        settle();
        check("full_b1", 32'(cnt_b1), 32'd15);
        check("full_b0", 32'(cnt_b0), 32'd15);
        adv();
        for (int k = 0; k < 8; k++) begin
            wr0_en = 1; wr0_addr = 4'(2*k+1); wr0_data = 16'(16'h0101 * (2*k+1));
            if (k < 7) begin
                wr1_en = 1; wr1_addr = 4'(2*k+2); wr1_data = 16'(16'h0101 * (2*k+2));
            end
            settle();
            check("drain_cnt", 32'(cnt_b1), 32'(15 - 2*k));
            adv();
        end
        settle();
        check("drain_done_b1", 32'(cnt_b1), 32'd0);
        check("drain_done_b0", 32'(cnt_b0), 32'd0);
        adv();

        // Mid-run reset with busy bits set.
        do_issue(9, 0, 0);
        adv();
        rs1_addr = 9;
        settle();
        rst = 1'b0;
        #1;
        check("mid_rst_cnt",  32'(cnt_b1), 32'd0);
        check("mid_rst_busy", 32'(rs1_busy_b1), 32'd0);
        check("mid_rst_data", 32'(rs1_data_b1), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle();
        adv();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised next-generation CPU register file with two write ports, optional write-to-read bypass and a per-register busy scoreboard. It sits between decode/issue and the writeback stage. It supplies operands, flags RAW/WAW hazards and produces an issue-stall signal. Register 0 is hardwired to zero and is never busy.

Parameters:
DATA_W, 16, register data width in bits
NREGS, 16, number of architectural registers (power of two, >=4)
ADDR_W, 4, register address width; must equal log2(NREGS)
BYPASS, 1, 1 = same-cycle write data and busy-clear visible on read ports; 0 = reads see stored state only

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
rs1_addr  input  ADDR_W  read port 1 address
rs2_addr  input  ADDR_W  read port 2 address
rs1_data  output  DATA_W  read port 1 data (combinational)
rs2_data  output  DATA_W  read port 2 data (combinational)
rs1_busy  output  1  rs1_addr has a pending write
rs2_busy  output  1  rs2_addr has a pending write
wr0_en  input  1  write port 0 (ALU) enable
wr0_addr  input  ADDR_W  write port 0 address
wr0_data  input  DATA_W  write port 0 data
wr1_en  input  1  write port 1 (load) enable
wr1_addr  input  ADDR_W  write port 1 address
wr1_data  input  DATA_W  write port 1 data
issue_valid  input  1  decode presents an instruction
issue_rd  input  ADDR_W  destination register of the issuing instruction
issue_use1  input  1  instruction reads rs1
issue_use2  input  1  instruction reads rs2
issue_stall  output  1  instruction must not issue this cycle
pending_cnt  output  ADDR_W+1  number of busy registers

Behaviour:
- Reset (rst=0, asynchronous): all registers <= 0, all busy bits <= 0, pending_cnt = 0. With addresses at 0, rs*_data = 0 and rs*_busy = 0. When rst is released, normal operation resumes on the next rising clock edge.
- Writes are registered on the rising edge. A write to address 0 is ignored.
- If wr0 and wr1 target the same nonzero address, wr1 data wins.
- Reads are combinational. Address 0 always returns data 0 and busy 0.
- BYPASS=1: if the read address matches an enabled write port this cycle, rs_data = that port's data (wr1 has priority) and rs_busy = 0.
- BYPASS=0: reads return the stored value and the stored busy bit.
- Busy clear: any enabled write to a nonzero address clears that register's busy bit at the clock edge.
- Busy set: the busy bit for issue_rd is set at the edge when issue_valid=1, issue_stall=0 and issue_rd != 0.
- Same register cleared and set in the same cycle: set wins, so the bit stays 1.
- issue_stall = issue_valid & ((issue_use1 & rs1_busy) | (issue_use2 & rs2_busy) | waw).
  - waw = effective busy of issue_rd, using the same bypass rule as the read ports.
  - The rs*_busy terms use the bypass-adjusted values.
- issue_stall = 0 whenever issue_valid = 0.
- pending_cnt is registered and equals the popcount of the busy bits after each edge. It is updated incrementally: +1 for a set, -1 for each distinct register cleared, net 0 for a register both set and cleared.
- Writes to a register that is not busy are legal and change no busy state.
- At most NREGS-1 registers can be busy, so pending_cnt never overflows.

Test Plan:
- Reset: drive rst=0 mid-run with busy bits set → all reads return 0, pending_cnt=0, issue_stall=0. Release rst, write R5=0x1234, then read rs1_addr=5 → 0x1234.
- R0: wr0 to addr 0 with 0xFFFF; issue with issue_rd=0 → rs1_data(0)=0, no busy bit set, pending_cnt unchanged.
- Port priority: wr0 and wr1 both write R3 with 0x1111 and 0x2222 → R3=0x2222. BYPASS=1 same-cycle read of R3 → 0x2222.
- RAW: issue rd=4, next cycle issue with use1 and rs1=4 → issue_stall=1. With the wr0 write of R4=0xBEEF in the same cycle: BYPASS=1 gives stall=0 and rs1_data=0xBEEF; BYPASS=0 gives stall=1 in that cycle and stall=0 on the next cycle.
- Set/clear collision: R6 busy; in one cycle wr1 writes R6 and a new issue has rd=6 → R6 stays busy, pending_cnt unchanged. Issue rd=6 while R6 busy → WAW stall=1.
- Counter: issue rd=1..15 in consecutive cycles → pending_cnt=15. Write back all 15, two per cycle → pending_cnt decrements by 2 per cycle and reaches 0.
